line_mem_slow: RTL and testbench

//   Slow, line-granular main memory sitting directly downstream of the set-associative

---
 rtl/line_mem_slow.sv | 83 ++++++++
 tb/tb_line_mem_slow.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/line_mem_slow.sv
// line_mem_slow: serial line-granular backing memory with fixed latency and traffic counters
module line_mem_slow #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN = 10,
  parameter int LATENCY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic rd_req,
  output logic [31:0] rd_line [1<<LINE_ADDR_LEN],
  input  logic wr_req,
  input  logic [31:0] wr_line [1<<LINE_ADDR_LEN],
  output logic gnt,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int DEPTH = 1 << ADDR_LEN;
  localparam int LW = 32 * LINE_SIZE;
  localparam logic [7:0] START_CNT = LATENCY > 1 ? 8'(LATENCY - 2) : 8'd0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic start, enter_done, c_wr, l_wr;
  logic [ADDR_LEN-1:0] c_addr, l_addr;
  logic [LW-1:0] c_line, l_line, wr_flat, rd_q;
  logic [LW-1:0] rows [DEPTH];
  function automatic logic [LW-1:0] init_line(input int a);
    logic [LW-1:0] l;
    for (int w = 0; w < LINE_SIZE; w++) l[w*32 +: 32] = 32'((a << LINE_ADDR_LEN) | w);
    return l;
  endfunction
  for (genvar w = 0; w < LINE_SIZE; w++) begin : g_word
    assign wr_flat[w*32 +: 32] = wr_line[w];
    assign rd_line[w] = rd_q[w*32 +: 32];
  end
  // with LATENCY==1 the commit happens on the sampling edge, so operands bypass the latches
  always_comb begin
    start = state == IDLE && (wr_req || rd_req);
    state_n = state == DONE ? IDLE :
              state == BUSY ? (cnt == 8'd0 ? DONE : BUSY) :
              start ? (LATENCY == 1 ? DONE : BUSY) : IDLE;
    cnt_n = start ? START_CNT : (state == BUSY && cnt != 8'd0) ? cnt - 8'd1 : cnt;
    enter_done = state != DONE && state_n == DONE;
    c_wr = state == IDLE ? wr_req : l_wr;
    c_addr = state == IDLE ? addr : l_addr;
    c_line = state == IDLE ? wr_flat : l_line;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 8'd0;
      gnt <= 1'b0;
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
      rd_q <= '0;
      l_wr <= 1'b0;
      l_addr <= '0;
      l_line <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gnt <= enter_done;
      if (start) begin
        l_wr <= wr_req;
        l_addr <= addr;
        l_line <= wr_flat;
      end
      if (enter_done && c_wr) wr_cnt <= wr_cnt + 32'd1;
      if (enter_done && !c_wr) begin
        rd_q <= rows[c_addr];
        rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end
  for (genvar a = 0; a < DEPTH; a++) begin : g_line
    logic [LW-1:0] row;
    always_ff @(posedge clk)
      row <= rst ? init_line(a) : (enter_done && c_wr && c_addr == ADDR_LEN'(a)) ? c_line : row;
    assign rows[a] = row;
  end
endmodule

// File: tb/tb_line_mem_slow.sv
// tb_line_mem_slow: directed and random line transactions against an array-based memory model
module tb_line_mem_slow;
  localparam int LAT = 8;
  localparam int LS = 8;
  localparam int AL = 10;
  localparam int DEPTH = 1 << AL;
  typedef logic [31:0] line_t [LS];
  logic clk = 1'b0, rst = 1'b1, rd_req = 1'b0, wr_req = 1'b0, gnt;
  logic [AL-1:0] addr = '0;
  logic [31:0] rd_line [LS];
  line_t wr_line;
  logic [31:0] rd_cnt, wr_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem_m [DEPTH][LS];
  line_t rd_m;
  logic [31:0] rd_cnt_m, wr_cnt_m;

  always #5 clk = ~clk;

  line_mem_slow #(.LINE_ADDR_LEN(3), .ADDR_LEN(AL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .rd_line(rd_line),
    .wr_req(wr_req), .wr_line(wr_line), .gnt(gnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  function automatic logic [255:0] pk(input line_t l);
    logic [255:0] p;
    for (int w = 0; w < LS; w++) p[w*32 +: 32] = l[w];
    return p;
  endfunction

  function automatic line_t fill(input logic [31:0] v);
    line_t l;
    for (int w = 0; w < LS; w++) l[w] = v;
    return l;
  endfunction

  function automatic line_t rnd_line();
    line_t l;
    for (int w = 0; w < LS; w++) l[w] = $urandom;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // every line holds its own word addresses after reset
  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++)
      for (int w = 0; w < LS; w++) mem_m[a][w] = 32'(a * LS + w);
    rd_m = fill(32'd0);
    rd_cnt_m = 32'd0;
    wr_cnt_m = 32'd0;
  endtask

  task automatic chk_all(input string tag, input bit exp_gnt);
    chk({tag, ".gnt"}, 256'(gnt), 256'(exp_gnt));
    chk({tag, ".rd_line"}, pk(rd_line), pk(rd_m));
    chk({tag, ".rd_cnt"}, 256'(rd_cnt), 256'(rd_cnt_m));
    chk({tag, ".wr_cnt"}, 256'(wr_cnt), 256'(wr_cnt_m));
  endtask

  // request visible in cycle c must be granted in cycle c+LAT, once
  task automatic txn(input bit wr, input bit rd, input logic [AL-1:0] a, input line_t l,
                     input bit one_shot, input int tail, input string tag);
    @(negedge clk);
    addr = a; wr_req = wr; rd_req = rd; wr_line = l;
    for (int k = 1; k <= LAT + tail; k++) begin
      @(negedge clk);
      if (one_shot && k == 1) begin
        wr_req = 1'b0; rd_req = 1'b0; addr = a + AL'(5);
        for (int w = 0; w < LS; w++) wr_line[w] = ~l[w];
      end
      if (k == LAT) begin
        if (wr) begin mem_m[a] = l; wr_cnt_m++; end
        else if (rd) begin rd_m = mem_m[a]; rd_cnt_m++; end
      end
      chk_all($sformatf("%s.c%0d", tag, k), k == LAT);
      if (k == LAT) begin wr_req = 1'b0; rd_req = 1'b0; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    wr_line = fill(32'd0);
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0);
    rst = 1'b0;
    txn(1'b0, 1'b1, 10'h005, fill(32'd0), 1'b0, 2, "t1");
    chk("t1.w0", 256'(rd_line[0]), 256'(32'h28));
    chk("t1.w7", 256'(rd_line[7]), 256'(32'h2f));
    txn(1'b1, 1'b0, 10'h3ff, fill(32'hdeadbeef), 1'b0, 2, "t2w");
    txn(1'b0, 1'b1, 10'h3ff, fill(32'd0), 1'b0, 2, "t2r");
    chk("t2.word", 256'(rd_line[3]), 256'(32'hdeadbeef));
    txn(1'b1, 1'b1, 10'h010, fill(32'h1234), 1'b0, 2, "t3w");
    chk("t3.rd_cnt", 256'(rd_cnt), 256'(32'd2));
    txn(1'b0, 1'b1, 10'h010, fill(32'd0), 1'b0, 2, "t3r");
    chk("t3.word", 256'(rd_line[5]), 256'(32'h1234));
    txn(1'b0, 1'b1, 10'h002, fill(32'd0), 1'b1, 4, "t4");
    chk("t4.w1", 256'(rd_line[1]), 256'(32'h11));
    @(negedge clk);
    addr = 10'h001; wr_req = 1'b1; wr_line = fill(32'hffffffff);
    repeat (4) begin
      @(negedge clk);
      chk_all("t5.busy", 1'b0);
    end
    rst = 1'b1; wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_all("t5.rst", 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk_all("t5.idle", 1'b0);
    end
    txn(1'b0, 1'b1, 10'h001, fill(32'd0), 1'b0, 2, "t5r");
    chk("t5.w2", 256'(rd_line[2]), 256'(32'h0a));
    txn(1'b1, 1'b0, 10'h020, rnd_line(), 1'b0, 0, "t6w");
    txn(1'b0, 1'b1, 10'h030, fill(32'd0), 1'b0, 2, "t6r");
    chk("t6.w4", 256'(rd_line[4]), 256'(32'h184));
    repeat (40) begin
      int op;
      logic [AL-1:0] a;
      op = $urandom_range(0, 3);
      a = AL'($urandom_range(0, 15)) | (op == 3 ? AL'($urandom_range(0, 63) << 4) : AL'(0));
      txn(op == 1 || op == 2, op != 1, a, rnd_line(), 1'b0, $urandom_range(0, 2), "rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
